// File: rtl/sim_ctrl_mmio.sv
// rtl/sim_ctrl_mmio.sv - memory-mapped test controller: verdict FSM, watchdog, console FIFO
// Console FIFO and stream exist only when SIM_CTRL_CONSOLE_EN is defined.
module sim_ctrl_mmio #(
  parameter logic [3:0]       BASE_NIBBLE = 4'h1,
  parameter logic [31:0]      PASS_CODE   = 32'h777,
  parameter int unsigned      FIFO_DEPTH  = 16,
  parameter int unsigned      WDT_W       = 32,
  parameter logic [WDT_W-1:0] WDT_LIMIT   = '0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] dbus_cmd_addr_i,
  input  logic        dbus_cmd_we_i,
  input  logic [31:0] dbus_write_data_i,
  output logic        done_o,
  output logic        pass_o,
  output logic        timeout_o,
  output logic [31:0] code_o,
  output logic        cons_valid_o,
  output logic [7:0]  cons_data_o,
  input  logic        cons_ready_i,
  output logic        cons_ovf_o
);

  typedef enum logic [1:0] {RUN, PASS, FAIL, TIMEOUT} state_e;

  state_e           state, state_next;
  logic [31:0]      code_next;
  logic [WDT_W-1:0] wdt_cnt;
  logic             hit, status_hit, console_hit, kick_hit, wdt_expire;

  assign hit         = dbus_cmd_we_i && (dbus_cmd_addr_i[31:28] == BASE_NIBBLE);
  assign status_hit  = hit && (dbus_cmd_addr_i[3:2] == 2'd0);
  assign console_hit = hit && (dbus_cmd_addr_i[3:2] == 2'd1);
  assign kick_hit    = hit && (dbus_cmd_addr_i[3:2] == 2'd2);

  // A kick on the expiry edge rescues the test.
  assign wdt_expire = (WDT_LIMIT != '0) && (wdt_cnt == WDT_LIMIT) && !kick_hit;

  logic [25:0] unused_addr;
  assign unused_addr = {dbus_cmd_addr_i[27:4], dbus_cmd_addr_i[1:0]};

  always_comb begin
    state_next = state;
    code_next  = code_o;
    case (state)
      RUN: begin
        if (status_hit) begin
          state_next = (dbus_write_data_i == PASS_CODE) ? PASS : FAIL;
          code_next  = dbus_write_data_i;
        end else if (wdt_expire) begin
          state_next = TIMEOUT;
          code_next  = 32'hFFFF_FFFF;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= RUN;
      code_o    <= '0;
      done_o    <= 1'b0;
      pass_o    <= 1'b0;
      timeout_o <= 1'b0;
      wdt_cnt   <= '0;
    end else begin
      state     <= state_next;
      code_o    <= code_next;
      done_o    <= (state_next != RUN);
      pass_o    <= (state_next == PASS);
      timeout_o <= (state_next == TIMEOUT);
      if (state == RUN) begin
        if (kick_hit)
          wdt_cnt <= '0;
        else if (wdt_cnt != {WDT_W{1'b1}})
          wdt_cnt <= wdt_cnt + 1'b1;
      end
    end
  end

`ifdef SIM_CTRL_CONSOLE_EN
  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        empty, full, push, pop;

  // Extra pointer MSB distinguishes full from empty when the low bits match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop   = !empty && cons_ready_i;
  assign push  = console_hit && (!full || pop);

  assign cons_valid_o = !empty;
  assign cons_data_o  = empty ? 8'h00 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      cons_ovf_o <= 1'b0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem[i] <= 8'h00;
    end else begin
      if (push) begin
        mem[wr_ptr[AW-1:0]] <= dbus_write_data_i[7:0];
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (console_hit && full && !pop) cons_ovf_o <= 1'b1;
    end
  end
`else
  logic [31:0] unused_depth;
  logic [1:0]  unused_cons;
  assign unused_depth = FIFO_DEPTH;
  assign unused_cons  = {cons_ready_i, console_hit};

  assign cons_valid_o = 1'b0;
  assign cons_data_o  = 8'h00;
  assign cons_ovf_o   = 1'b0;
`endif

endmodule

// File: tb/tb_sim_ctrl_mmio.sv
// tb/tb_sim_ctrl_mmio.sv - scoreboard bench for sim_ctrl_mmio (WDT_LIMIT=10, FIFO_DEPTH=4)
module tb_sim_ctrl_mmio;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] addr = '0;
  logic        we = 1'b0;
  logic [31:0] wdata = '0;
  logic        done, pass, tout;
  logic [31:0] code;
  logic        cons_valid;
  logic [7:0]  cons_data;
  logic        cons_ready = 1'b0;
  logic        cons_ovf;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc;
  logic done_q = 1'b0;

  logic [63:0] exp_v[$];
  logic [7:0]  exp_b[$];

  sim_ctrl_mmio #(
    .BASE_NIBBLE(4'h1), .PASS_CODE(32'h777), .FIFO_DEPTH(4),
    .WDT_W(32), .WDT_LIMIT(32'd10)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .dbus_cmd_addr_i(addr), .dbus_cmd_we_i(we), .dbus_write_data_i(wdata),
    .done_o(done), .pass_o(pass), .timeout_o(tout), .code_o(code),
    .cons_valid_o(cons_valid), .cons_data_o(cons_data),
    .cons_ready_i(cons_ready), .cons_ovf_o(cons_ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Verdict record: {cycle at which done_o first reads high, pass, timeout, code}
  function automatic logic [63:0] vrec(input int c, input logic p, input logic t, input logic [31:0] k);
    return {14'b0, c[15:0], p, t, k};
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      done_q = 1'b0;
    end else begin
      if (done && !done_q) begin
        if (exp_v.size() == 0) chk("verdict_unexpected", vrec(cyc, pass, tout, code), 64'hX);
        else chk("verdict", vrec(cyc, pass, tout, code), exp_v.pop_front());
      end
      done_q = done;
      if (cons_valid && cons_ready) begin
        if (exp_b.size() == 0) chk("cons_unexpected", {56'b0, cons_data}, 64'hX);
        else chk("cons_byte", {56'b0, cons_data}, {56'b0, exp_b.pop_front()});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    we = 1'b0;
    cons_ready = 1'b0;
    exp_v.delete();
    exp_b.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    addr = a;
    wdata = d;
    we = 1'b1;
    tick();
    we = 1'b0;
  endtask

  task automatic expect_verdict(input logic p, input logic t, input logic [31:0] k);
    exp_v.push_back(vrec(cyc + 1, p, t, k));
  endtask

  task automatic drained(input string name);
    chk(name, 64'(exp_v.size() + exp_b.size()), 64'd0);
  endtask

  initial begin
    do_reset();

    chk("rst_done", {63'b0, done}, 64'd0);
    chk("rst_pass", {63'b0, pass}, 64'd0);
    chk("rst_timeout", {63'b0, tout}, 64'd0);
    chk("rst_code", {32'b0, code}, 64'd0);
    chk("rst_cons_valid", {63'b0, cons_valid}, 64'd0);
    chk("rst_cons_data", {56'b0, cons_data}, 64'd0);
    chk("rst_cons_ovf", {63'b0, cons_ovf}, 64'd0);

    // No kicks: TIMEOUT on edge 11 after reset release.
    exp_v.push_back(vrec(11, 1'b0, 1'b1, 32'hFFFF_FFFF));
    repeat (14) tick();
    drained("timeout_seen");
    chk("timeout_sticky", {63'b0, tout}, 64'd1);

    // Kick every 8 cycles, then out-of-region and offset-3 stores, then a fail code.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      store(32'h1000_0008, 32'h0);
      repeat (7) tick();
    end
    store(32'h2000_0000, 32'h777);
    store(32'h1000_000C, 32'h777);
    chk("kicked_no_timeout", {63'b0, tout}, 64'd0);
    chk("ignored_stores", {63'b0, done}, 64'd0);
    expect_verdict(1'b0, 1'b0, 32'hDEAD);
    store(32'h1000_0000, 32'hDEAD);
    tick();
    drained("fail_seen");
    store(32'h1000_0000, 32'h777);
    store(32'h1000_0008, 32'h0);
    chk("fail_code_sticky", {32'b0, code}, 64'h0000_DEAD);
    chk("fail_pass_sticky", {63'b0, pass}, 64'd0);

    // Pass with the code captured; later STATUS store and watchdog both frozen.
    do_reset();
    expect_verdict(1'b1, 1'b0, 32'h777);
    store(32'h1ABC_DEF0, 32'h777);
    store(32'h1000_0000, 32'h5);
    repeat (15) tick();
    drained("pass_seen");
    chk("pass_code_sticky", {32'b0, code}, 64'h777);
    chk("pass_wdt_frozen", {63'b0, tout}, 64'd0);

    // STATUS store on the expiry edge wins, for both fail and pass data.
    do_reset();
    repeat (10) tick();
    expect_verdict(1'b0, 1'b0, 32'hDEAD);
    store(32'h1000_0000, 32'hDEAD);
    tick();
    drained("coincident_fail");
    do_reset();
    repeat (10) tick();
    expect_verdict(1'b1, 1'b0, 32'h777);
    store(32'h1000_0000, 32'h777);
    tick();
    drained("coincident_pass");

    // Kick on the expiry edge restarts the count: timeout 11 cycles later.
    do_reset();
    repeat (10) tick();
    exp_v.push_back(vrec(22, 1'b0, 1'b1, 32'hFFFF_FFFF));
    store(32'h1000_0008, 32'h1234);
    repeat (15) tick();
    drained("kick_beats_expiry");

    do_reset();
    expect_verdict(1'b1, 1'b0, 32'h777);
    store(32'h1000_0000, 32'h777);
`ifdef SIM_CTRL_CONSOLE_EN
    // Five pushes into a depth-4 FIFO with the consumer stalled.
    for (int i = 0; i < 5; i++) begin
      if (i < 4) exp_b.push_back(8'h41 + 8'(i));
      store(32'h1000_0004, 32'h1234_5600 | (32'h41 + i));
    end
    chk("ovf_set", {63'b0, cons_ovf}, 64'd1);
    chk("head_held", {55'b0, cons_valid, cons_data}, {55'b0, 1'b1, 8'h41});
    cons_ready = 1'b1;
    repeat (4) tick();
    cons_ready = 1'b0;
    drained("abcd_drained");
    chk("empty_after_drain", {63'b0, cons_valid}, 64'd0);

    // Full FIFO: push with a simultaneous pop is accepted.
    do_reset();
    expect_verdict(1'b1, 1'b0, 32'h777);
    store(32'h1000_0000, 32'h777);
    for (int i = 1; i <= 4; i++) begin
      exp_b.push_back(8'(i));
      store(32'h1000_0004, 32'(i));
    end
    cons_ready = 1'b1;
    exp_b.push_back(8'h05);
    store(32'h1000_0004, 32'h05);
    cons_ready = 1'b0;
    chk("full_push_pop_no_ovf", {63'b0, cons_ovf}, 64'd0);
    chk("full_push_pop_head", {56'b0, cons_data}, 64'h02);
    store(32'h1000_0004, 32'h06);
    chk("still_full_ovf", {63'b0, cons_ovf}, 64'd1);
    cons_ready = 1'b1;
    repeat (2) tick();
`else
    for (int i = 0; i < 5; i++) store(32'h1000_0004, 32'h41 + i);
    chk("nocons_valid", {63'b0, cons_valid}, 64'd0);
    chk("nocons_ovf", {63'b0, cons_ovf}, 64'd0);
    cons_ready = 1'b1;
    tick();
    chk("nocons_data", {55'b0, cons_valid, cons_data}, 64'd0);
`endif

    // Asynchronous reset mid-operation with the verdict reached.
    chk("pre_reset_done", {63'b0, done}, 64'd1);
    exp_b.delete();
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_flags", {60'b0, done, pass, tout, cons_ovf}, 64'd0);
    chk("async_rst_code", {32'b0, code}, 64'd0);
    chk("async_rst_cons", {55'b0, cons_valid, cons_data}, 64'd0);
    do_reset();
    tick();
    chk("post_reset_idle", {62'b0, done, cons_valid}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/sim_ctrl_mmio.md
# sim_ctrl_mmio

Memory-mapped simulation/test controller attached to the CPU data bus in `main`. Decodes stores to a configurable address region, ends a test with a sticky pass/fail verdict and captured code, buffers console characters in a FIFO drained by a valid/ready stream, and runs a kickable watchdog. It replaces ad-hoc testbench store snooping with a parametrised, synthesizable block usable in both simulation and FPGA builds.

## Interface
- `BASE_NIBBLE`, 4'h1: region select, matched against `dbus_cmd_addr_i[31:28]`.
- `PASS_CODE`, 32'h777: status-register value meaning pass.
- `FIFO_DEPTH`, 16: console FIFO entries; power of two, 2..256.
- `WDT_W`, 32: watchdog counter width.
- `WDT_LIMIT`, 0: cycles without a kick before timeout; 0 disables the watchdog.
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `dbus_cmd_addr_i`  in  32  store address.
- `dbus_cmd_we_i`  in  1  store strobe; one store per high cycle.
- `dbus_write_data_i`  in  32  store data.
- `done_o`  out  1  sticky: verdict reached.
- `pass_o`  out  1  sticky: verdict is pass.
- `timeout_o`  out  1  sticky: watchdog expired.
- `code_o`  out  32  captured status value (fail code, or PASS_CODE).
- `cons_valid_o`  out  1  console byte available.
- `cons_data_o`  out  8  console byte (FIFO head).
- `cons_ready_i`  in  1  consumer accepts byte.
- `cons_ovf_o`  out  1  sticky: console byte dropped.

## Operation
- Hit: `dbus_cmd_we_i` && `addr[31:28]==BASE_NIBBLE`. Offset `addr[3:2]`: 0 STATUS, 1 CONSOLE, 2 KICK, 3 ignored. Bits [27:4] ignored.
- FSM states RUN, PASS, FAIL, TIMEOUT; reset to RUN. Only RUN leaves.
- RUN, STATUS hit, data==PASS_CODE → PASS: `code_o`=data, `done_o`=`pass_o`=1.
- RUN, STATUS hit, other data → FAIL: `code_o`=data, `done_o`=1, `pass_o`=0.
- RUN, watchdog count reaches WDT_LIMIT (limit≠0) → TIMEOUT: `done_o`=`timeout_o`=1, `pass_o`=0, `code_o`=32'hFFFF_FFFF.
- STATUS hit and watchdog expiry in same cycle: STATUS wins.
- In PASS/FAIL/TIMEOUT all STATUS and KICK hits ignored; watchdog frozen. CONSOLE hits still accepted.
- Watchdog: counter increments each RUN cycle, saturating at all-ones; KICK hit (any data) clears it to 0 that edge, taking priority over increment and over expiry on the same cycle.
- CONSOLE hit pushes `data[7:0]`. FIFO full with no pop in that cycle: byte dropped, `cons_ovf_o` set. Full with pop same cycle: push accepted.
- Pop on `cons_valid_o && cons_ready_i`. Pointers are log2(FIFO_DEPTH)+1 bits, wrap naturally; full = MSBs differ, low bits equal.

## Timing
- Reset values: FSM RUN, `done_o`/`pass_o`/`timeout_o`/`cons_valid_o`/`cons_ovf_o`=0, `code_o`=0, `cons_data_o`=0, watchdog=0, FIFO empty.
- All outputs registered; verdict visible the cycle after the STATUS store edge (latency 1).
- Expiry: TIMEOUT asserted on the edge where counter equals WDT_LIMIT, i.e. WDT_LIMIT+1 cycles after reset release or last kick with no further kick.
- Console: push into empty FIFO → `cons_valid_o` high next cycle. Back-to-back push/pop sustains 1 byte/cycle. `cons_data_o` stable while valid && !ready.
- Reset asserted mid-operation clears everything asynchronously, including FIFO contents and sticky flags.

## Configuration
- `SIM_CTRL_CONSOLE_EN` defined: console FIFO and stream present as above.
- Not defined: no FIFO storage; CONSOLE hits ignored; `cons_valid_o`, `cons_data_o`, `cons_ovf_o` tied to 0; `cons_ready_i` unused. Ports remain.

## Test plan
- STATUS store 32'h777 at 0x1000_0000 → next cycle `done_o`=1, `pass_o`=1, `code_o`=32'h777; later STATUS store 32'h5 → no change.
- STATUS store 32'hDEAD at 0x1000_0000 → `done_o`=1, `pass_o`=0, `code_o`=32'hDEAD; store 32'h777 to 0x2000_0000 before it → ignored.
- WDT_LIMIT=10, no kicks → `timeout_o`=1, `code_o`=32'hFFFF_FFFF at cycle 11 after reset; kick at 0x1000_0008 every 8 cycles → never times out.
- FIFO_DEPTH=4, `cons_ready_i`=0, push "ABCDE" via 0x1000_0004 → `cons_ovf_o`=1, then ready=1 drains 'A','B','C','D' in order, one per cycle.
- Full FIFO, push and pop same cycle → no overflow, occupancy stays 4; STATUS store coincident with expiry → FAIL/PASS per data, `timeout_o`=0.
- Assert `rst_ni` low mid-drain with `done_o`=1 → all outputs 0 immediately; build without `SIM_CTRL_CONSOLE_EN` → console stores leave `cons_valid_o`=0.
